// File: rtl/symbol_pkg.sv
// Shared types for the symbol input encoder: symbol codes, FSM states and
// the symbol stepping rule.
package symbol_pkg;

    typedef logic [1:0] symbol_t;

    localparam symbol_t SYM_EMPTY = 2'b00;
    localparam symbol_t SYM_A     = 2'b01;
    localparam symbol_t SYM_B     = 2'b10;

    typedef enum logic [1:0] {
        EDIT   = 2'b00,
        COMMIT = 2'b01,
        HOLD   = 2'b10
    } enc_state_t;

    // Code 11 is never produced; an illegal input recovers to EMPTY.
    function automatic symbol_t next_symbol(input symbol_t cur);
        symbol_t nxt;
        case (cur)
            SYM_EMPTY: nxt = SYM_A;
            SYM_A:     nxt = SYM_B;
            SYM_B:     nxt = SYM_EMPTY;
            default:   nxt = SYM_EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one active-low push button, producing the
// debounced level and a one-cycle pulse on each accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [1:0]       fill_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             level_d_r;
    logic             armed_r;
    logic             press_r;

    // Synchronizer, debounce counter and press edge detector.
    // armed_r is only set once the real button has been seen released, so a
    // button held through reset release never yields a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r    <= 2'b11;
            fill_r    <= 2'b00;
            cnt_r     <= {CNT_W{1'b0}};
            level_r   <= 1'b1;
            level_d_r <= 1'b1;
            armed_r   <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], btn_n};
            fill_r    <= {fill_r[0], 1'b1};
            armed_r   <= armed_r | (fill_r[1] & sync_r[1]);
            level_d_r <= level_r;
            press_r   <= level_d_r & ~level_r & armed_r;
            if (sync_r[1] == level_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync_r[1];
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/symbol_input_encoder.sv
// Two-channel symbol selector driven by debounced push buttons, with a lock
// button that commits, freezes and later clears the selected pair.
module symbol_input_encoder
    import symbol_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_step_n,
    input  logic       btn_lock_n,
    output logic [1:0] bin1,
    output logic [1:0] bin2,
    output logic       locked,
    output logic       commit,
    output logic       reject
);

    logic [1:0] step_press_s;
    logic       lock_press_s;
    logic [2:0] levels_unused_s;

    enc_state_t state_r;
    enc_state_t next_state_s;
    symbol_t    bin1_r;
    symbol_t    bin2_r;
    symbol_t    bin1_nxt_s;
    symbol_t    bin2_nxt_s;
    logic       reject_nxt_s;
    logic       locked_r;
    logic       commit_r;
    logic       reject_r;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step1_db (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_step_n[0]),
        .level (levels_unused_s[0]),
        .press (step_press_s[0])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step2_db (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_step_n[1]),
        .level (levels_unused_s[1]),
        .press (step_press_s[1])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lock_db (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_lock_n),
        .level (levels_unused_s[2]),
        .press (lock_press_s)
    );

    // Next state and next codes; a lock press takes priority over steps.
    always_comb begin
        next_state_s = state_r;
        bin1_nxt_s   = bin1_r;
        bin2_nxt_s   = bin2_r;
        reject_nxt_s = 1'b0;
        case (state_r)
            EDIT: begin
                if (lock_press_s) begin
                    if ((bin1_r != SYM_EMPTY) && (bin2_r != SYM_EMPTY)) begin
                        next_state_s = COMMIT;
                    end else begin
                        reject_nxt_s = 1'b1;
                    end
                end else begin
                    if (step_press_s[0]) begin
                        bin1_nxt_s = next_symbol(bin1_r);
                    end else begin
                        bin1_nxt_s = bin1_r;
                    end
                    if (step_press_s[1]) begin
                        bin2_nxt_s = next_symbol(bin2_r);
                    end else begin
                        bin2_nxt_s = bin2_r;
                    end
                end
            end
            COMMIT: begin
                next_state_s = HOLD;
            end
            HOLD: begin
                if (lock_press_s) begin
                    next_state_s = EDIT;
                    bin1_nxt_s   = SYM_EMPTY;
                    bin2_nxt_s   = SYM_EMPTY;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = EDIT;
                bin1_nxt_s   = SYM_EMPTY;
                bin2_nxt_s   = SYM_EMPTY;
            end
        endcase
    end

    // State, code and output registers; flags are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= EDIT;
            bin1_r   <= SYM_EMPTY;
            bin2_r   <= SYM_EMPTY;
            locked_r <= 1'b0;
            commit_r <= 1'b0;
            reject_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            bin1_r   <= bin1_nxt_s;
            bin2_r   <= bin2_nxt_s;
            locked_r <= (next_state_s == HOLD);
            commit_r <= (next_state_s == COMMIT);
            reject_r <= reject_nxt_s;
        end
    end

    assign bin1   = bin1_r;
    assign bin2   = bin2_r;
    assign locked = locked_r;
    assign commit = commit_r;
    assign reject = reject_r;

endmodule

// File: tb/tb_symbol_input_encoder.sv
// Directed and randomized bench for symbol_input_encoder, compared every
// cycle against a behavioural model of the button and lock rules.
module tb_symbol_input_encoder;

    localparam int D  = 4;
    localparam int HL = D + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_step_n;
    logic       btn_lock_n;
    logic [1:0] bin1;
    logic [1:0] bin2;
    logic       locked;
    logic       commit;
    logic       reject;

    always #5 clk = ~clk;

    symbol_input_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step_n (btn_step_n),
        .btn_lock_n (btn_lock_n),
        .bin1       (bin1),
        .bin2       (bin2),
        .locked     (locked),
        .commit     (commit),
        .reject     (reject)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_value(input string tag, input logic [1:0] got, input logic [1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: raw history per button (index 0 = newest), accepted level,
    // pending press pipeline and a plain mode number 0=edit 1=commit 2=hold.
    logic       hist_m [0:2][0:HL-1];
    logic       lvl_m   [0:2];
    logic       armed_m [0:2];
    logic       fell_m  [0:2];
    logic       press_m [0:2];
    int         since_rst_m;
    int         mode_m;
    logic [1:0] b1_m, b2_m;
    logic       locked_m, commit_m, reject_m;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < HL; k++) hist_m[b][k] = 1'b1;
            lvl_m[b]   = 1'b1;
            armed_m[b] = 1'b0;
            fell_m[b]  = 1'b0;
            press_m[b] = 1'b0;
        end
        since_rst_m = 0;
        mode_m      = 0;
        b1_m        = 2'd0;
        b2_m        = 2'd0;
        locked_m    = 1'b0;
        commit_m    = 1'b0;
        reject_m    = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] raw);
        logic [2:0] p;
        logic       all_diff;
        since_rst_m++;
        for (int b = 0; b < 3; b++) p[b] = press_m[b];
        commit_m = 1'b0;
        reject_m = 1'b0;
        if (mode_m == 0) begin
            if (p[2]) begin
                if (b1_m != 2'd0 && b2_m != 2'd0) begin
                    mode_m   = 1;
                    commit_m = 1'b1;
                end else begin
                    reject_m = 1'b1;
                end
            end else begin
                if (p[0]) b1_m = 2'((int'(b1_m) + 1) % 3);
                if (p[1]) b2_m = 2'((int'(b2_m) + 1) % 3);
            end
        end else if (mode_m == 1) begin
            mode_m = 2;
        end else if (p[2]) begin
            b1_m   = 2'd0;
            b2_m   = 2'd0;
            mode_m = 0;
        end
        locked_m = (mode_m == 2);
        for (int b = 0; b < 3; b++) begin
            press_m[b] = fell_m[b];
            for (int k = HL - 1; k > 0; k--) hist_m[b][k] = hist_m[b][k-1];
            hist_m[b][0] = raw[b];
            // a sample only reflects the real button two edges after reset
            if (since_rst_m >= 3 && hist_m[b][2]) armed_m[b] = 1'b1;
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
                if (hist_m[b][k] == lvl_m[b]) all_diff = 1'b0;
            end
            fell_m[b] = 1'b0;
            if (all_diff) begin
                lvl_m[b]  = ~lvl_m[b];
                fell_m[b] = ~lvl_m[b] & armed_m[b];
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [1:0] s, input logic l);
        @(negedge clk);
        rst        = r;
        btn_step_n = s;
        btn_lock_n = l;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_edge({l, s});
        check_value("bin1",   bin1,           b1_m);
        check_value("bin2",   bin2,           b2_m);
        check_value("locked", {1'b0, locked}, {1'b0, locked_m});
        check_value("commit", {1'b0, commit}, {1'b0, commit_m});
        check_value("reject", {1'b0, reject}, {1'b0, reject_m});
    endtask

    task automatic run(input logic r, input logic [1:0] s, input logic l, input int n);
        for (int i = 0; i < n; i++) cycle(r, s, l);
    endtask

    int         hold_left [0:2];
    logic [2:0] cur;

    initial begin
        rst        = 1'b1;
        btn_step_n = 2'b11;
        btn_lock_n = 1'b1;
        model_reset();
        run(1'b1, 2'b11, 1'b1, 3);
        run(1'b0, 2'b11, 1'b1, 3);
        // single held press on channel 1
        run(1'b0, 2'b10, 1'b1, 10);
        run(1'b0, 2'b11, 1'b1, 12);
        // three presses on channel 2 wrap back to EMPTY
        for (int i = 0; i < 3; i++) begin
            run(1'b0, 2'b01, 1'b1, 6);
            run(1'b0, 2'b11, 1'b1, 10);
        end
        // bouncy press on channel 1
        run(1'b0, 2'b10, 1'b1, 3);
        run(1'b0, 2'b11, 1'b1, 1);
        run(1'b0, 2'b10, 1'b1, 3);
        run(1'b0, 2'b11, 1'b1, 1);
        run(1'b0, 2'b10, 1'b1, 10);
        run(1'b0, 2'b11, 1'b1, 10);
        // lock with channel 2 empty is refused
        run(1'b0, 2'b11, 1'b0, 6);
        run(1'b0, 2'b11, 1'b1, 10);
        // step channel 2, then lock commits
        run(1'b0, 2'b01, 1'b1, 6);
        run(1'b0, 2'b11, 1'b1, 10);
        run(1'b0, 2'b11, 1'b0, 6);
        run(1'b0, 2'b11, 1'b1, 10);
        // steps ignored in hold
        run(1'b0, 2'b00, 1'b1, 6);
        run(1'b0, 2'b11, 1'b1, 10);
        // lock and step together in hold: clear, no advance
        run(1'b0, 2'b10, 1'b0, 6);
        run(1'b0, 2'b11, 1'b1, 10);
        // both channels step together
        run(1'b0, 2'b00, 1'b1, 6);
        run(1'b0, 2'b11, 1'b1, 10);
        // lock, then reset in the commit cycle with lock still held
        run(1'b0, 2'b11, 1'b0, 3 + D + 1);
        run(1'b1, 2'b11, 1'b0, 2);
        run(1'b0, 2'b11, 1'b0, 15);
        run(1'b0, 2'b11, 1'b1, 12);
        // reset mid-debounce with step held through release
        run(1'b0, 2'b10, 1'b1, 3);
        run(1'b1, 2'b10, 1'b1, 2);
        run(1'b0, 2'b10, 1'b1, 15);
        run(1'b0, 2'b11, 1'b1, 12);
        // randomized button activity with rare resets
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        cur = 3'b111;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    if (b == 2) cur[b] = ($urandom_range(0, 2) != 0);
                    else        cur[b] = 1'($urandom_range(0, 1));
                    hold_left[b] = $urandom_range(1, 14);
                end
                hold_left[b]--;
            end
            cycle(($urandom_range(0, 799) == 0), cur[1:0], cur[2]);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
